// File: rtl/core_bus_arb_pkg.sv
// Shared types for the core bus arbiter: source IDs and arbitration modes.
package core_bus_pkg;
  typedef enum logic {SRC_ISTR = 1'b0, SRC_DATA = 1'b1} bus_src_e;
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
endpackage

// File: rtl/core_bus_arb_if.sv
// Avalon-MM bus bundle; the master drives commands, the slave answers.
interface i_avl_bus;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (output address, read, write, writedata, byteenable,
                  input  readdata, readdatavalid, waitrequest);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/core_bus_arb_idfifo.sv
// Source-ID FIFO for outstanding reads; push is refused when full, even on a same-cycle pop.
module core_bus_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/core_bus_arb.sv
// Merges the core's instruction and data Avalon masters onto one memory port,
// steering pipelined read returns back by source ID.
module core_bus_arb
  import core_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = ARB_RR
) (
  input  logic                                 clk,
  input  logic                                 rest,
  i_avl_bus.slave                              avl_s0_istr,
  i_avl_bus.slave                              avl_s1_data,
  i_avl_bus.master                             avl_m0,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_unexp_rdv
);
  bus_src_e    gnt, head, last_q, last_d, lsrc_q, lsrc_d;
  logic        lock_q, lock_d, err_q, err_d;
  logic        req_i, req_d, gnt_vld, out_en;
  logic        sel_rd, sel_wr, cmd_rd, cmd_wr, accept, stall_wr;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [0:0]  fifo_din, fifo_dout;

  assign req_i = avl_s0_istr.read | avl_s0_istr.write;
  assign req_d = avl_s1_data.read | avl_s1_data.write;

  always_comb begin
    gnt     = SRC_ISTR;
    gnt_vld = 1'b0;
    if (lock_q) begin
      gnt     = lsrc_q;
      gnt_vld = 1'b1;
    end else if (req_i && req_d) begin
      gnt_vld = 1'b1;
      if (ARB_MODE == ARB_FIXED) gnt = SRC_DATA;
      else gnt = (last_q == SRC_ISTR) ? SRC_DATA : SRC_ISTR;
    end else if (req_d) begin
      gnt     = SRC_DATA;
      gnt_vld = 1'b1;
    end else if (req_i) begin
      gnt_vld = 1'b1;
    end
  end

  assign sel_rd    = (gnt == SRC_DATA) ? avl_s1_data.read       : avl_s0_istr.read;
  assign sel_wr    = (gnt == SRC_DATA) ? avl_s1_data.write      : avl_s0_istr.write;
  assign sel_addr  = (gnt == SRC_DATA) ? avl_s1_data.address    : avl_s0_istr.address;
  assign sel_wdata = (gnt == SRC_DATA) ? avl_s1_data.writedata  : avl_s0_istr.writedata;
  assign sel_be    = (gnt == SRC_DATA) ? avl_s1_data.byteenable : avl_s0_istr.byteenable;

  assign cmd_rd   = gnt_vld & sel_rd & ~fifo_full;
  assign cmd_wr   = gnt_vld & sel_wr;
  assign accept   = (cmd_rd | cmd_wr) & ~avl_m0.waitrequest;
  assign stall_wr = avl_m0.waitrequest | (sel_rd & fifo_full);

  // Reset only masks the outward command; internal state is already held in reset.
  assign out_en            = rest & gnt_vld;
  assign avl_m0.read       = rest & cmd_rd;
  assign avl_m0.write      = rest & cmd_wr;
  assign avl_m0.address    = out_en ? sel_addr  : '0;
  assign avl_m0.writedata  = out_en ? sel_wdata : '0;
  assign avl_m0.byteenable = out_en ? sel_be    : '0;

  assign avl_s0_istr.waitrequest = (gnt_vld && gnt == SRC_ISTR) ? stall_wr : 1'b1;
  assign avl_s1_data.waitrequest = (gnt_vld && gnt == SRC_DATA) ? stall_wr : 1'b1;

  assign head      = bus_src_e'(fifo_dout);
  assign fifo_din  = gnt;
  assign fifo_push = accept & cmd_rd;
  assign fifo_pop  = avl_m0.readdatavalid & ~fifo_empty;

  assign avl_s0_istr.readdatavalid = fifo_pop & (head == SRC_ISTR);
  assign avl_s1_data.readdatavalid = fifo_pop & (head == SRC_DATA);
  assign avl_s0_istr.readdata      = avl_m0.readdata;
  assign avl_s1_data.readdata      = avl_m0.readdata;

  always_comb begin
    lock_d = lock_q;
    lsrc_d = lsrc_q;
    last_d = last_q;
    err_d  = err_q | (avl_m0.readdatavalid & fifo_empty);
    if (accept) begin
      lock_d = 1'b0;
      last_d = gnt;
    end else if (gnt_vld && (sel_rd || sel_wr)) begin
      // Stalled: pin the grant so the held command is never switched away.
      lock_d = 1'b1;
      lsrc_d = gnt;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      lock_q <= 1'b0;
      lsrc_q <= SRC_ISTR;
      last_q <= SRC_ISTR;
      err_q  <= 1'b0;
    end else begin
      lock_q <= lock_d;
      lsrc_q <= lsrc_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  assign err_unexp_rdv = err_q;

  core_bus_arb_idfifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(1)) u_idfifo (
    .clk   (clk),
    .rest  (rest),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );
endmodule

// File: tb/tb_core_bus_arb.sv
// Scoreboard bench for core_bus_arb: round-robin and fixed-priority instances share stimulus.
module tb_core_bus_arb;
  import core_bus_pkg::*;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} cmd_t;
  typedef struct packed {logic p; logic [31:0] data;} ret_t;
  typedef struct packed {int due; logic [31:0] data;} pend_t;

  logic clk = 1'b0, rest = 1'b0;
  always #5 clk = ~clk;

  int   nchk = 0, nfail = 0, cyc = 0, lat = 3;
  logic fx = 1'b0, hold = 1'b0, stray = 1'b0, mem_wait = 1'b0, mem_rdv = 1'b0;
  logic [31:0] mem_rdata = '0;
  cmd_t c0 = '0, c1 = '0;
  logic v0 = 1'b0, v1 = 1'b0, a0 = 1'b0, a1 = 1'b0;
  cmd_t  q0[$], q1[$], ecmd[$];
  ret_t  sb[$];
  pend_t pend[$];
  bit    exp_gnt[$];

  i_avl_bus rr_s0(), rr_s1(), rr_m(), fx_s0(), fx_s1(), fx_m();
  logic [2:0] rr_outs, fx_outs;
  logic       rr_err, fx_err;

  assign rr_s0.address = c0.addr;  assign rr_s0.writedata = c0.wdata;  assign rr_s0.byteenable = c0.be;
  assign rr_s0.read = v0 & ~c0.we; assign rr_s0.write = v0 & c0.we;
  assign fx_s0.address = c0.addr;  assign fx_s0.writedata = c0.wdata;  assign fx_s0.byteenable = c0.be;
  assign fx_s0.read = v0 & ~c0.we; assign fx_s0.write = v0 & c0.we;
  assign rr_s1.address = c1.addr;  assign rr_s1.writedata = c1.wdata;  assign rr_s1.byteenable = c1.be;
  assign rr_s1.read = v1 & ~c1.we; assign rr_s1.write = v1 & c1.we;
  assign fx_s1.address = c1.addr;  assign fx_s1.writedata = c1.wdata;  assign fx_s1.byteenable = c1.be;
  assign fx_s1.read = v1 & ~c1.we; assign fx_s1.write = v1 & c1.we;
  assign rr_m.waitrequest = mem_wait; assign rr_m.readdatavalid = mem_rdv | stray; assign rr_m.readdata = mem_rdata;
  assign fx_m.waitrequest = mem_wait; assign fx_m.readdatavalid = mem_rdv | stray; assign fx_m.readdata = mem_rdata;

  core_bus_arb #(.MAX_OUTSTANDING(4), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rest(rest), .avl_s0_istr(rr_s0), .avl_s1_data(rr_s1), .avl_m0(rr_m),
    .outstanding(rr_outs), .err_unexp_rdv(rr_err));
  core_bus_arb #(.MAX_OUTSTANDING(4), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rest(rest), .avl_s0_istr(fx_s0), .avl_s1_data(fx_s1), .avl_m0(fx_m),
    .outstanding(fx_outs), .err_unexp_rdv(fx_err));

  // Observed view of whichever instance the current test targets.
  logic s0_wr, s0_rdv, s1_wr, s1_rdv, m_rd, m_wr, err;
  logic [31:0] s0_rdata, s1_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [2:0]  outs;
  assign s0_wr    = fx ? fx_s0.waitrequest   : rr_s0.waitrequest;
  assign s1_wr    = fx ? fx_s1.waitrequest   : rr_s1.waitrequest;
  assign s0_rdv   = fx ? fx_s0.readdatavalid : rr_s0.readdatavalid;
  assign s1_rdv   = fx ? fx_s1.readdatavalid : rr_s1.readdatavalid;
  assign s0_rdata = fx ? fx_s0.readdata      : rr_s0.readdata;
  assign s1_rdata = fx ? fx_s1.readdata      : rr_s1.readdata;
  assign m_rd     = fx ? fx_m.read           : rr_m.read;
  assign m_wr     = fx ? fx_m.write          : rr_m.write;
  assign m_addr   = fx ? fx_m.address        : rr_m.address;
  assign m_wdata  = fx ? fx_m.writedata      : rr_m.writedata;
  assign m_be     = fx ? fx_m.byteenable     : rr_m.byteenable;
  assign outs     = fx ? fx_outs             : rr_outs;
  assign err      = fx ? fx_err              : rr_err;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic cmd_t rd(input logic [31:0] a);
    cmd_t c = '0;
    c.addr = a;
    c.be   = 4'hF;
    return c;
  endfunction

  function automatic cmd_t wrc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.we = 1'b1; c.addr = a; c.wdata = d; c.be = be;
    return c;
  endfunction

  task automatic slave_acc(input bit p, input cmd_t c);
    ret_t r;
    ecmd.push_back(c);
    if (!c.we) begin
      r.p = p; r.data = memf(c.addr);
      sb.push_back(r);
    end
    if (exp_gnt.size() > 0) chk("gnt_order", 64'(p), 64'(exp_gnt.pop_front()));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Masters and memory drive just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (!v0 || a0) begin a0 = 1'b0; if (q0.size() > 0) begin c0 = q0.pop_front(); v0 = 1'b1; end else v0 = 1'b0; end
    if (!v1 || a1) begin a1 = 1'b0; if (q1.size() > 0) begin c1 = q1.pop_front(); v1 = 1'b1; end else v1 = 1'b0; end
    mem_rdv = 1'b0;
    if (!hold && pend.size() > 0 && pend[0].due <= cyc) begin
      pend_t pp;
      pp = pend.pop_front();
      mem_rdv   = 1'b1;
      mem_rdata = pp.data;
    end
  end

  // Acceptance and return monitor, sampled on the falling edge.
  always @(negedge clk) if (rest) begin
    assert (!(rr_s0.read && rr_s0.write) && !(rr_s1.read && rr_s1.write));
    if (v0 && !a0 && !s0_wr) begin a0 = 1'b1; slave_acc(1'b0, c0); end
    if (v1 && !a1 && !s1_wr) begin a1 = 1'b1; slave_acc(1'b1, c1); end
    if ((m_rd || m_wr) && !mem_wait) begin
      if (ecmd.size() == 0) chk("cmd_unexpected", 64'(1), 64'(0));
      else begin
        cmd_t e;
        pend_t pp;
        e = ecmd.pop_front();
        chk("cmd_addr", 64'(m_addr), 64'(e.addr));
        chk("cmd_we", 64'(m_wr), 64'(e.we));
        if (e.we) begin
          chk("cmd_wdata", 64'(m_wdata), 64'(e.wdata));
          chk("cmd_be", 64'(m_be), 64'(e.be));
        end
        if (m_rd) begin
          pp.due = cyc + lat; pp.data = memf(m_addr);
          pend.push_back(pp);
        end
      end
    end
    if (s0_rdv && s1_rdv) chk("rdv_both_ports", 64'(1), 64'(0));
    else if (s0_rdv || s1_rdv) begin
      if (sb.size() == 0) chk("rdv_unexpected", 64'(1), 64'(0));
      else begin
        ret_t e;
        e = sb.pop_front();
        chk("ret_port", 64'(s1_rdv), 64'(e.p));
        chk("ret_data", 64'(s1_rdv ? s1_rdata : s0_rdata), 64'(e.data));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (q0.size() > 0 || q1.size() > 0 || (v0 && !a0) || (v1 && !a1) ||
           pend.size() > 0 || sb.size() > 0) begin
      @(negedge clk); #1;
      n++;
      if (n > budget) begin chk("idle_timeout", 64'(n), 64'(budget)); break; end
    end
    @(negedge clk);
    chk("idle_outstanding", 64'(outs), 64'(0));
    chk("idle_gnt_left", 64'(exp_gnt.size()), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rest = 1'b0;
    q0.delete(); q1.delete(); ecmd.delete(); sb.delete(); pend.delete(); exp_gnt.delete();
    hold = 1'b0; mem_wait = 1'b0;
    repeat (2) @(posedge clk);
    #2 rest = 1'b1;
  endtask

  initial begin
    int n;
    // Reset with an istr read already presented: the merged port must stay quiet.
    q0.push_back(rd(32'h100));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_read", 64'(m_rd), 64'(0));
    chk("rst_m_write", 64'(m_wr), 64'(0));
    chk("rst_m_addr", 64'(m_addr), 64'(0));
    chk("rst_outstanding", 64'(outs), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdv", 64'({s0_rdv, s1_rdv}), 64'(0));

    // Single istr read, 3-cycle memory latency.
    @(posedge clk); #1 rest = 1'b1;
    n = 0;
    while (!a0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("t1_accepted", 64'(a0), 64'(1));
    @(negedge clk);
    chk("t1_outstanding", 64'(outs), 64'(1));
    wait_idle(50);

    // Round-robin: data wins first tie after reset, then strict alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rd(32'h1000 + 32'(i * 4)));
      q1.push_back(rd(32'h2000 + 32'(i * 4)));
      exp_gnt.push_back(1'b1);
      exp_gnt.push_back(1'b0);
    end
    wait_idle(100);

    // Fixed priority: data writes every cycle starve istr reads until data idles.
    fx = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q1.push_back(wrc(32'h3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1)));
      exp_gnt.push_back(1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rd(32'h5000 + 32'(i * 4)));
      exp_gnt.push_back(1'b0);
    end
    wait_idle(100);
    fx = 1'b0;

    // Lock: memory stalls istr for 5 cycles while data starts requesting.
    do_reset();
    mem_wait = 1'b1;
    q0.push_back(rd(32'h200));
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1);
    @(posedge clk); #2;
    q1.push_back(rd(32'h300));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_addr", 64'(m_addr), 64'(32'h200));
      chk("t4_hold_read", 64'(m_rd), 64'(1));
      if (k > 0) chk("t4_data_wait", 64'(s1_wr), 64'(1));
    end
    @(posedge clk); #1 mem_wait = 1'b0;
    wait_idle(50);

    // FIFO full: 5th read waits; a same-cycle return does not admit it.
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) q1.push_back(rd(32'h4000 + 32'(i * 4)));
    n = 0;
    while (outs != 3'd4 && n < 20) begin @(negedge clk); n++; end
    chk("t5_full_count", 64'(outs), 64'(4));
    chk("t5_full_wait", 64'(s1_wr), 64'(1));
    chk("t5_full_gate", 64'(m_rd), 64'(0));
    #1 hold = 1'b0;
    @(negedge clk);
    chk("t5_pop_rdv", 64'(s1_rdv), 64'(1));
    chk("t5_pop_gate", 64'(m_rd), 64'(0));
    chk("t5_pop_wait", 64'(s1_wr), 64'(1));
    @(negedge clk);
    chk("t5_next_read", 64'(m_rd), 64'(1));
    chk("t5_next_wait", 64'(s1_wr), 64'(0));
    wait_idle(50);

    // Stray readdatavalid with nothing outstanding.
    @(posedge clk); #1 stray = 1'b1;
    @(negedge clk);
    chk("t6_no_rdv", 64'({s0_rdv, s1_rdv}), 64'(0));
    @(posedge clk); #1 stray = 1'b0;
    chk("t6_err_set", 64'(err), 64'(1));
    #2 rest = 1'b0;
    #1 chk("t6_err_async_clr", 64'(err), 64'(0));
    @(posedge clk); #1 rest = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/core_bus_arb.md
Name: core_bus_arb

Overview:
- Sits directly downstream of the core's two Avalon masters: the instruction-fetch port (avl_m0_istr) and the data port (avl_m1_data).
- Merges both onto a single Avalon master port that drives the memory/interconnect.
- Supports pipelined reads with up to MAX_OUTSTANDING reads in flight.
- A source-ID FIFO routes each returning readdata beat back to the core port that issued the read.

Parameters:
- MAX_OUTSTANDING, 4, depth of the outstanding-read ID FIFO; must be ≥1.
- ARB_MODE, 0, 0 = round-robin between ports, 1 = fixed priority with the data port always winning.

Ports:
- clk  input  1  single clock; all state is rising-edge.
- rest  input  1  reset; asynchronous, active-low.
- avl_s0_istr  i_avl_bus.slave  -  instruction-side port; connects to core avl_m0_istr.
- avl_s1_data  i_avl_bus.slave  -  data-side port; connects to core avl_m1_data.
- avl_m0  i_avl_bus.master  -  merged port toward memory.
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  current FIFO occupancy.
- err_unexp_rdv  output  1  sticky flag: readdatavalid arrived while the FIFO was empty.

Interface fields used: address[31:0], read, write, writedata[31:0], byteenable[3:0], readdata[31:0], readdatavalid, waitrequest.

Behaviour:
- Reset (rest=0, asynchronous):
  - FIFO empty; outstanding=0; err_unexp_rdv=0; lock=0.
  - last_grant=ISTR, so in round-robin mode the data port wins the first tie.
  - On reset all avl_m0 command outputs are 0 and slave readdatavalid=0. These are combinational from state, so they follow reset immediately.
- Request: port p requests when its read or write is asserted. Simultaneous read and write on one port is illegal; the bench asserts it never occurs.
- Grant selection, combinational each cycle:
  - If lock=1, keep the current grant.
  - Else if only one port requests, grant it.
  - Else if both request: ARB_MODE=1 grants data; ARB_MODE=0 grants the port that is not last_grant.
- Command path, zero latency, combinational:
  - avl_m0 address/read/write/writedata/byteenable mirror the granted port.
  - With no grant, read=write=0.
- Back-pressure:
  - Granted port sees waitrequest = avl_m0.waitrequest | (read & fifo_full).
  - While fifo_full, avl_m0.read is gated to 0.
  - The non-granted port sees waitrequest=1 whenever it requests.
- Acceptance:
  - A command is accepted when avl_m0 read or write is asserted and avl_m0.waitrequest=0.
  - On acceptance: lock←0 and last_grant←granted port.
  - An accepted read pushes the granted port ID (1 bit) into the FIFO.
- Lock:
  - When the granted port requests but is stalled, lock←1.
  - This holds the grant so the Avalon master-hold rule is never violated by a grant switch.
- Read return:
  - On avl_m0.readdatavalid with the FIFO non-empty, pop the head ID.
  - Drive readdatavalid=1 and readdata on that port only; the other port sees readdatavalid=0.
  - readdata is broadcast to both ports; only readdatavalid is steered.
  - Zero added latency.
- Simultaneous push and pop:
  - Allowed when the FIFO is not full; occupancy is unchanged.
  - When full, the push is blocked even if a pop occurs the same cycle (no bypass).
  - The freed slot is usable the next cycle.
- Unexpected readdatavalid: FIFO empty and readdatavalid=1 → data dropped, err_unexp_rdv←1. It stays set until reset.
- Writes:
  - Never enter the FIFO and never produce a return.
  - A write may be accepted while reads are outstanding.
  - Read/write ordering toward memory is acceptance order.
- Wrap-around: FIFO pointers are modulo MAX_OUTSTANDING; a non-power-of-two depth is supported via explicit wrap compare.
- Reset mid-transaction: in-flight reads are forgotten. Stray returns after reset set err_unexp_rdv, which is acceptable and documented.

Decomposition:
- Shared package core_bus_pkg holds:
  - typedef enum logic {SRC_ISTR=1'b0, SRC_DATA=1'b1} bus_src_e;
  - localparams ARB_RR=0 and ARB_FIXED=1.
- One sub-module, core_bus_arb_idfifo: synchronous ID FIFO.
  - Parameters: depth, width.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-low reset.

Test Plan:
- Single istr read at 0x100, memory returns 0xDEADBEEF after 3 cycles → avl_s0_istr readdatavalid=1 with 0xDEADBEEF; avl_s1_data readdatavalid stays 0; outstanding goes 1→0.
- Both ports read the same cycle, ARB_MODE=0, after reset → data granted first, istr next cycle. Returns in order map to data then istr; last_grant alternates across 4 back-to-back pairs.
- ARB_MODE=1, istr reading continuously and data writing every cycle → data write always wins. Istr waits until data idles; the istr address is held stable with waitrequest=1.
- avl_m0.waitrequest held 1 for 5 cycles while istr is granted and data starts requesting → grant stays on istr (lock). Data is granted only after istr is accepted.
- Issue 4 reads with no returns (MAX_OUTSTANDING=4) → outstanding=4 and a 5th read sees waitrequest=1 with avl_m0.read=0. A return in the same cycle does not admit the 5th; it is accepted the next cycle.
- readdatavalid pulse with no outstanding reads → err_unexp_rdv=1 and neither port sees readdatavalid. Assert rest=0 → flag clears asynchronously.
